// File: rtl/ac_eco_controller.sv
// ac_eco_controller
// Economy-mode supervisor for the HVAC path. It forces the AC off once any
// window or door stays open longer than a grace period. After every contact
// has closed again, it keeps the AC off for a restart hold time. It also
// exports the current state, a popcount of open contacts, a shutdown pulse
// and a saturating shutdown counter.
//
// Optional feature: define AC_ECO_SYNC_EN to pass eco_mode_valid_i,
// WINDOW_STATUS_i and DOOR_STATUS_i through 2-flop synchronizers. This adds
// two cycles to every input-to-output latency.

// Contact counts normally come from design_constant.vh; these defaults only
// apply when that header has not been included ahead of this file.
`ifndef HOME_WINDOW_COUNT
`define HOME_WINDOW_COUNT 4
`endif
`ifndef HOME_DOOR_COUNT
`define HOME_DOOR_COUNT 2
`endif

module ac_eco_controller #(
   parameter int WIN_N             = `HOME_WINDOW_COUNT,
   parameter int DOOR_N            = `HOME_DOOR_COUNT,
   parameter int OPEN_DELAY_CYC    = 16,
   parameter int RESTART_DELAY_CYC = 32,
   parameter int CNT_W             = 8
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  eco_mode_valid_i,
   input  logic [WIN_N-1:0]                      WINDOW_STATUS_i,
   input  logic [DOOR_N-1:0]                     DOOR_STATUS_i,
   output logic                                  close_ac_o,
   output logic [1:0]                            state_o,
   output logic [$clog2(WIN_N+DOOR_N+1)-1:0]     open_count_o,
   output logic                                  shutdown_pulse_o,
   output logic [7:0]                            shutdown_cnt_o
);

   localparam int CONTACT_N = WIN_N + DOOR_N;
   localparam int OC_W      = $clog2(CONTACT_N + 1);

   // Terminal timer values. A delay of 2^CNT_W maps to an all-ones terminal
   // value, so the full documented range fits in the timer.
   localparam logic [CNT_W-1:0] OPEN_LAST    = CNT_W'(OPEN_DELAY_CYC - 1);
   localparam logic [CNT_W-1:0] RESTART_LAST = CNT_W'(RESTART_DELAY_CYC - 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_GRACE = 2'b01,
      ST_OFF   = 2'b10,
      ST_HOLD  = 2'b11
   } state_t;

   // Inputs as seen by the supervisor (after optional synchronization)
   logic                 eco_s;
   logic [CONTACT_N-1:0] contacts_s;
   logic                 any_open;
   logic [OC_W-1:0]      open_sum;

   state_t               state_q;
   logic [CNT_W-1:0]     timer_q;

`ifdef AC_ECO_SYNC_EN
   // Bit CONTACT_N carries eco; the lower bits carry {doors, windows}
   logic [CONTACT_N:0] sync_q1;
   logic [CONTACT_N:0] sync_q2;

   // Two-stage synchronizer for the mode bit and every contact
   // NOTE: the synchronizer flops are reset to 0 so that no phantom "open"
   // or "eco" value reaches the FSM during the first cycles after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= {eco_mode_valid_i, DOOR_STATUS_i, WINDOW_STATUS_i};
         sync_q2 <= sync_q1;
      end
   end

   assign eco_s      = sync_q2[CONTACT_N];
   assign contacts_s = sync_q2[CONTACT_N-1:0];
`else
   // Inputs are already in the clk_i domain and are used directly
   assign eco_s      = eco_mode_valid_i;
   assign contacts_s = {DOOR_STATUS_i, WINDOW_STATUS_i};
`endif

   assign any_open = |contacts_s;

   // Population count of open contacts
   // NOTE: open_sum gets its default before the loop, so every path assigns
   // it and no latch can be inferred.
   always_comb begin
      open_sum = '0;
      for (int i = 0; i < CONTACT_N; i++) begin
         open_sum = open_sum + OC_W'(contacts_s[i]);
      end
   end

   // Open-contact count, registered every cycle regardless of eco or state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         open_count_o <= '0;
      end else begin
         open_count_o <= open_sum;
      end
   end

   // Supervisor FSM with the shared delay timer and registered outputs.
   // Priority in every state: eco off, then any_open change, then expiry.
   // NOTE: all state in this block uses non-blocking assignments, so each
   // branch sees the values from before the edge and the default pulse
   // clear below is cleanly overridden by a later assignment.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q          <= ST_RUN;
         timer_q          <= '0;
         close_ac_o       <= 1'b0;
         shutdown_pulse_o <= 1'b0;
         shutdown_cnt_o   <= 8'd0;
      end else begin
         shutdown_pulse_o <= 1'b0;
         case (state_q)
            ST_RUN: begin
               if (eco_s && any_open) begin
                  state_q <= ST_GRACE;
                  timer_q <= '0;
               end
            end

            ST_GRACE: begin
               if (!eco_s || !any_open) begin
                  state_q <= ST_RUN;
                  timer_q <= '0;
               end else if (timer_q == OPEN_LAST) begin
                  state_q          <= ST_OFF;
                  timer_q          <= '0;
                  close_ac_o       <= 1'b1;
                  shutdown_pulse_o <= 1'b1;
                  if (shutdown_cnt_o != 8'hFF) begin
                     shutdown_cnt_o <= shutdown_cnt_o + 8'd1;
                  end
               end else begin
                  timer_q <= timer_q + CNT_W'(1);
               end
            end

            ST_OFF: begin
               if (!eco_s) begin
                  state_q    <= ST_RUN;
                  timer_q    <= '0;
                  close_ac_o <= 1'b0;
               end else if (!any_open) begin
                  state_q <= ST_HOLD;
                  timer_q <= '0;
               end
            end

            ST_HOLD: begin
               if (!eco_s) begin
                  state_q    <= ST_RUN;
                  timer_q    <= '0;
                  close_ac_o <= 1'b0;
               end else if (any_open) begin
                  // Re-opening during the hold is not a new shutdown
                  state_q <= ST_OFF;
                  timer_q <= '0;
               end else if (timer_q == RESTART_LAST) begin
                  state_q    <= ST_RUN;
                  timer_q    <= '0;
                  close_ac_o <= 1'b0;
               end else begin
                  timer_q <= timer_q + CNT_W'(1);
               end
            end

            default: begin
               state_q    <= ST_RUN;
               timer_q    <= '0;
               close_ac_o <= 1'b0;
            end
         endcase
      end
   end

   assign state_o = state_q;

endmodule
